// File: rtl/prog_delay_line.sv
// Runtime-programmable, stallable delay line for a data word plus valid qualifier.
// A delay load flushes in-flight valids and reports refill progress on busy_o.
module prog_delay_line #(
  parameter int unsigned SIGNAL_WIDTH = 8,
  parameter int unsigned MAX_DELAY    = 16,
  parameter int unsigned DLY_W        = $clog2(MAX_DELAY + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    en_i,
  input  logic                    valid_i,
  input  logic [SIGNAL_WIDTH-1:0] data_i,
  input  logic [DLY_W-1:0]        delay_i,
  input  logic                    delay_load_i,
  output logic                    valid_o,
  output logic [SIGNAL_WIDTH-1:0] data_o,
  output logic [DLY_W-1:0]        delay_o,
  output logic                    busy_o,
  output logic                    clamp_o
);

  localparam int unsigned IDX_W = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;

  logic [MAX_DELAY-1:0]    vld_q;
  logic [MAX_DELAY-1:0]    vld_d;
  logic [SIGNAL_WIDTH-1:0] dat_q [MAX_DELAY];
  logic [DLY_W-1:0]        delay_q;
  logic [DLY_W-1:0]        delay_new;
  logic [DLY_W-1:0]        cnt_q;
  logic [DLY_W-1:0]        cnt_d;
  logic                    clamp_q;
  logic                    over_max;
  logic [IDX_W-1:0]        tap_idx;

  // Requested delay saturated to the number of physical stages.
  always_comb begin
    over_max  = (delay_i > DLY_W'(MAX_DELAY));
    delay_new = over_max ? DLY_W'(MAX_DELAY) : delay_i;
  end

  // Valid shift; a load drops all history but keeps the sample entering this cycle.
  always_comb begin
    vld_d = vld_q;
    if (en_i) begin
      vld_d[0] = valid_i;
      for (int unsigned k = 1; k < MAX_DELAY; k++) begin
        vld_d[k] = vld_q[k-1];
      end
    end
    if (delay_load_i) begin
      vld_d    = '0;
      vld_d[0] = en_i & valid_i;
    end
  end

  // Refill counter: advances still needed before the tap shows post-load samples.
  always_comb begin
    cnt_d = cnt_q;
    if (delay_load_i) begin
      if (delay_new == '0) begin
        cnt_d = '0;
      end else if (en_i) begin
        cnt_d = delay_new - DLY_W'(1);
      end else begin
        cnt_d = delay_new;
      end
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - DLY_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q   <= '0;
      delay_q <= DLY_W'(MAX_DELAY);
      cnt_q   <= '0;
      clamp_q <= 1'b0;
      for (int unsigned k = 0; k < MAX_DELAY; k++) begin
        dat_q[k] <= '0;
      end
    end else begin
      vld_q   <= vld_d;
      cnt_q   <= cnt_d;
      clamp_q <= delay_load_i & over_max;
      if (delay_load_i) begin
        delay_q <= delay_new;
      end
      if (en_i) begin
        dat_q[0] <= data_i;
        for (int unsigned k = 1; k < MAX_DELAY; k++) begin
          dat_q[k] <= dat_q[k-1];
        end
      end
    end
  end

  // Output tap; delay 0 is a pure combinational bypass.
  always_comb begin
    tap_idx = IDX_W'(delay_q - DLY_W'(1));
    if (delay_q == '0) begin
      data_o  = data_i;
      valid_o = valid_i & en_i;
    end else begin
      data_o  = dat_q[tap_idx];
      valid_o = vld_q[tap_idx];
    end
  end

  assign delay_o = delay_q;
  assign busy_o  = (cnt_q != '0);
  assign clamp_o = clamp_q;

endmodule

// File: tb/tb_prog_delay_line.sv
// Directed self-checking bench for prog_delay_line with hand-computed expectations.
module tb_prog_delay_line;

  localparam int unsigned SW = 8;
  localparam int unsigned MD = 16;
  localparam int unsigned DW = $clog2(MD + 1);

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          en_i;
  logic          valid_i;
  logic [SW-1:0] data_i;
  logic [DW-1:0] delay_i;
  logic          delay_load_i;
  logic          valid_o;
  logic [SW-1:0] data_o;
  logic [DW-1:0] delay_o;
  logic          busy_o;
  logic          clamp_o;

  int checks   = 0;
  int failures = 0;

  prog_delay_line #(.SIGNAL_WIDTH(SW), .MAX_DELAY(MD)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .en_i        (en_i),
    .valid_i     (valid_i),
    .data_i      (data_i),
    .delay_i     (delay_i),
    .delay_load_i(delay_load_i),
    .valid_o     (valid_o),
    .data_o      (data_o),
    .delay_o     (delay_o),
    .busy_o      (busy_o),
    .clamp_o     (clamp_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic en, input logic vld, input logic [7:0] dat,
                       input logic load, input logic [DW-1:0] dly);
    en_i         = en;
    valid_i      = vld;
    data_i       = dat;
    delay_load_i = load;
    delay_i      = dly;
  endtask

  initial begin
    rst_i = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 1'b0, '0);
    step();
    step();
    rst_i = 1'b0;
    check("rst_valid", 8'(valid_o), 8'h00);
    check("rst_data",  data_o,      8'h00);
    check("rst_delay", 8'(delay_o), 8'd16);
    check("rst_busy",  8'(busy_o),  8'h00);
    check("rst_clamp", 8'(clamp_o), 8'h00);

    // Default delay of 16: sample j is at the tap after edge j+15.
    for (int j = 1; j <= 20; j++) begin
      drive(1'b1, 1'b1, 8'(j), 1'b0, '0);
      step();
      check("fix_busy",  8'(busy_o),  8'h00);
      check("fix_valid", 8'(valid_o), (j >= 16) ? 8'h01 : 8'h00);
      if (j >= 16) check("fix_data", data_o, 8'(j - 15));
    end

    // Load delay 3 while streaming.
    drive(1'b1, 1'b1, 8'd21, 1'b1, DW'(3));
    step();
    check("ld3_delay", 8'(delay_o), 8'd3);
    check("ld3_busy0", 8'(busy_o),  8'h01);
    check("ld3_vld0",  8'(valid_o), 8'h00);
    check("ld3_clamp", 8'(clamp_o), 8'h00);
    drive(1'b1, 1'b1, 8'd22, 1'b0, '0);
    step();
    check("ld3_busy1", 8'(busy_o),  8'h01);
    check("ld3_vld1",  8'(valid_o), 8'h00);
    drive(1'b1, 1'b1, 8'd23, 1'b0, '0);
    step();
    check("ld3_busy2", 8'(busy_o),  8'h00);
    check("ld3_vld2",  8'(valid_o), 8'h01);
    check("ld3_dat2",  data_o,      8'd21);
    drive(1'b1, 1'b1, 8'd24, 1'b0, '0);
    step();
    check("ld3_vld3",  8'(valid_o), 8'h01);
    check("ld3_dat3",  data_o,      8'd22);

    // Stall: delay 4, inject 0xA5, then alternate enable low/high.
    drive(1'b0, 1'b0, 8'h00, 1'b1, DW'(4));
    step();
    check("stl_delay", 8'(delay_o), 8'd4);
    check("stl_busyl", 8'(busy_o),  8'h01);
    check("stl_vldl",  8'(valid_o), 8'h00);
    drive(1'b1, 1'b1, 8'hA5, 1'b0, '0);
    step();
    check("stl_vld1",  8'(valid_o), 8'h00);
    for (int n = 2; n <= 4; n++) begin
      drive(1'b0, 1'b0, 8'h00, 1'b0, '0);
      step();
      check("stl_hold_vld", 8'(valid_o), 8'h00);
      drive(1'b1, 1'b0, 8'h00, 1'b0, '0);
      step();
      check("stl_vld",  8'(valid_o), (n == 4) ? 8'h01 : 8'h00);
      check("stl_busy", 8'(busy_o),  (n == 4) ? 8'h00 : 8'h01);
    end
    check("stl_dat", data_o, 8'hA5);
    drive(1'b0, 1'b0, 8'h00, 1'b0, '0);
    step();
    check("stl_hold_v", 8'(valid_o), 8'h01);
    check("stl_hold_d", data_o,      8'hA5);

    // Bypass at delay 0.
    drive(1'b1, 1'b0, 8'h00, 1'b1, DW'(0));
    step();
    check("byp_delay", 8'(delay_o), 8'd0);
    check("byp_busy",  8'(busy_o),  8'h00);
    drive(1'b1, 1'b1, 8'h3C, 1'b0, '0);
    #1;
    check("byp_dat0", data_o,      8'h3C);
    check("byp_vld0", 8'(valid_o), 8'h01);
    drive(1'b0, 1'b1, 8'h3C, 1'b0, '0);
    #1;
    check("byp_vld_stall", 8'(valid_o), 8'h00);
    drive(1'b1, 1'b1, 8'h5A, 1'b0, '0);
    #1;
    check("byp_dat1", data_o,      8'h5A);
    check("byp_vld1", 8'(valid_o), 8'h01);

    // Clamp: request 31 with a maximum of 16.
    drive(1'b0, 1'b0, 8'h00, 1'b1, DW'(31));
    step();
    check("clp_pulse", 8'(clamp_o), 8'h01);
    check("clp_delay", 8'(delay_o), 8'd16);
    check("clp_busy",  8'(busy_o),  8'h01);
    drive(1'b0, 1'b0, 8'h00, 1'b0, '0);
    step();
    check("clp_end",    8'(clamp_o), 8'h00);
    check("clp_delay2", 8'(delay_o), 8'd16);

    // Reset with samples in flight at delay 5.
    drive(1'b0, 1'b0, 8'h00, 1'b1, DW'(5));
    step();
    check("rm_delay", 8'(delay_o), 8'd5);
    drive(1'b1, 1'b1, 8'h11, 1'b0, '0); step();
    drive(1'b1, 1'b1, 8'h22, 1'b0, '0); step();
    drive(1'b1, 1'b1, 8'h33, 1'b0, '0); step();
    check("rm_pre_vld", 8'(valid_o), 8'h00);
    rst_i = 1'b1;
    drive(1'b1, 1'b1, 8'h44, 1'b1, DW'(2));
    step();
    rst_i = 1'b0;
    check("rm_vld",   8'(valid_o), 8'h00);
    check("rm_busy",  8'(busy_o),  8'h00);
    check("rm_delay16", 8'(delay_o), 8'd16);
    check("rm_clamp", 8'(clamp_o), 8'h00);
    check("rm_data",  data_o,      8'h00);
    for (int j = 0; j < 20; j++) begin
      drive(1'b1, 1'b0, 8'h00, 1'b0, '0);
      step();
      check("rm_drain_vld", 8'(valid_o), 8'h00);
    end

    // Reload while busy: 8, two advances, then 2.
    drive(1'b1, 1'b1, 8'h80, 1'b1, DW'(8));
    step();
    check("rl_delay8", 8'(delay_o), 8'd8);
    check("rl_busy8",  8'(busy_o),  8'h01);
    for (int j = 0; j < 2; j++) begin
      drive(1'b1, 1'b0, 8'h00, 1'b0, '0);
      step();
      check("rl_adv_vld",  8'(valid_o), 8'h00);
      check("rl_adv_busy", 8'(busy_o),  8'h01);
    end
    drive(1'b1, 1'b1, 8'h99, 1'b1, DW'(2));
    step();
    check("rl_delay2", 8'(delay_o), 8'd2);
    check("rl_busy2",  8'(busy_o),  8'h01);
    check("rl_vld2",   8'(valid_o), 8'h00);
    drive(1'b1, 1'b0, 8'h00, 1'b0, '0);
    step();
    check("rl_busy_drop", 8'(busy_o),  8'h00);
    check("rl_vld_new",   8'(valid_o), 8'h01);
    check("rl_dat_new",   data_o,      8'h99);
    for (int j = 0; j < 8; j++) begin
      drive(1'b1, 1'b0, 8'h00, 1'b0, '0);
      step();
      check("rl_no_stale", 8'(valid_o), 8'h00);
    end

    // Reloading the active delay still flushes and restarts busy.
    drive(1'b1, 1'b1, 8'h01, 1'b0, '0); step();
    drive(1'b1, 1'b1, 8'h02, 1'b0, '0); step();
    check("same_vld_pre", 8'(valid_o), 8'h01);
    check("same_dat_pre", data_o,      8'h01);
    drive(1'b0, 1'b0, 8'h00, 1'b1, DW'(2));
    step();
    check("same_vld",   8'(valid_o), 8'h00);
    check("same_busy",  8'(busy_o),  8'h01);
    check("same_delay", 8'(delay_o), 8'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
